// File: rtl/traffic_light_fsm_pkg.sv
// rtl/traffic_light_fsm_pkg.sv - shared types, BCD conversion and parameter range helpers
package traffic_pkg;

    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_e;

    localparam int PHASE_MIN = 1;
    localparam int PHASE_MAX = 99;

    function automatic logic [7:0] to_bcd(input int value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

    function automatic bit in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// rtl/traffic_light_fsm_if.sv - tick/pedestrian inputs and lamp/display outputs of the traffic light
interface traffic_light_fsm_if;
    logic       tick_1s;
    logic       ped_req;
    logic       red;
    logic       yellow;
    logic       green;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       ped_ack;

    modport master (
        output tick_1s, ped_req,
        input  red, yellow, green, sec_tens, sec_ones, ped_ack
    );

    modport slave (
        input  tick_1s, ped_req,
        output red, yellow, green, sec_tens, sec_ones, ped_ack
    );
endinterface

// File: rtl/traffic_light_fsm_bcd_down_counter.sv
// rtl/traffic_light_fsm_bcd_down_counter.sv - two-digit BCD down counter with priority load
module bcd_down_counter #(
    parameter logic [7:0] RESET_VAL = 8'h30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] q,
    output logic       is_one
);

    logic [7:0] q_dec;

    // Borrow from tens when ones wraps; the owner never decrements past 01.
    always_comb begin
        q_dec = q;
        if (q[3:0] != 4'd0) begin
            q_dec[3:0] = q[3:0] - 4'd1;
        end else begin
            q_dec[3:0] = 4'd9;
            q_dec[7:4] = q[7:4] - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (dec) begin
            q <= q_dec;
        end
    end

    assign is_one = (q == 8'h01);

endmodule

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - three-phase traffic light with BCD countdown and pedestrian green cut
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int GREEN_S  = 25,
    parameter int YELLOW_S = 5,
    parameter int RED_S    = 30,
    parameter int PED_MIN  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    traffic_light_fsm_if.slave  bus
);

    localparam logic [1:0] ST_RED    = S_RED;
    localparam logic [1:0] ST_GREEN  = S_GREEN;
    localparam logic [1:0] ST_YELLOW = S_YELLOW;

    localparam logic [7:0] RED_BCD    = to_bcd(RED_S);
    localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_S);
    localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_S);
    localparam logic [7:0] PED_BCD    = to_bcd(PED_MIN);

    if (!in_range(GREEN_S, PHASE_MIN, PHASE_MAX)) begin : g_bad_green
        $error("GREEN_S outside 1..99");
    end
    if (!in_range(YELLOW_S, PHASE_MIN, PHASE_MAX)) begin : g_bad_yellow
        $error("YELLOW_S outside 1..99");
    end
    if (!in_range(RED_S, PHASE_MIN, PHASE_MAX)) begin : g_bad_red
        $error("RED_S outside 1..99");
    end
    if (!in_range(PED_MIN, 1, GREEN_S)) begin : g_bad_ped
        $error("PED_MIN outside 1..GREEN_S");
    end

    logic [1:0] state;
    logic [1:0] next_state;
    logic       ped_pend;
    logic       ped_ack_r;
    logic       red_r;
    logic       yellow_r;
    logic       green_r;
    logic [7:0] q;
    logic       is_one;
    logic       terminal;
    logic       cut;
    logic       load;
    logic [7:0] load_val;

    assign terminal = bus.tick_1s && is_one;
    // BCD ordering matches numeric ordering, so the count compares directly.
    assign cut = bus.tick_1s && !is_one && (state == ST_GREEN)
              && (ped_pend || bus.ped_req) && (q > PED_BCD);
    assign load = terminal || cut;

    always_comb begin
        next_state = state;
        if (terminal) begin
            case (state)
                ST_RED:    next_state = ST_GREEN;
                ST_GREEN:  next_state = ST_YELLOW;
                default:   next_state = ST_RED;
            endcase
        end
    end

    always_comb begin
        load_val = PED_BCD;
        if (terminal) begin
            case (next_state)
                ST_GREEN:  load_val = GREEN_BCD;
                ST_YELLOW: load_val = YELLOW_BCD;
                default:   load_val = RED_BCD;
            endcase
        end
    end

    bcd_down_counter #(
        .RESET_VAL (RED_BCD)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .dec      (bus.tick_1s),
        .q        (q),
        .is_one   (is_one)
    );

    // Lamps track next_state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RED;
            ped_pend  <= 1'b0;
            ped_ack_r <= 1'b0;
            red_r     <= 1'b1;
            yellow_r  <= 1'b0;
            green_r   <= 1'b0;
        end else begin
            state     <= next_state;
            ped_ack_r <= cut;
            red_r     <= (next_state == ST_RED);
            yellow_r  <= (next_state == ST_YELLOW);
            green_r   <= (next_state == ST_GREEN);
            if (terminal && (state == ST_GREEN)) begin
                ped_pend <= 1'b0;
            end else if (cut) begin
                ped_pend <= 1'b0;
            end else if ((state == ST_GREEN) && bus.ped_req) begin
                ped_pend <= 1'b1;
            end
        end
    end

    assign bus.red      = red_r;
    assign bus.yellow   = yellow_r;
    assign bus.green    = green_r;
    assign bus.sec_tens = q[7:4];
    assign bus.sec_ones = q[3:0];
    assign bus.ped_ack  = ped_ack_r;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - randomized and directed bench for traffic_light_fsm against a seconds-level model
module tb_traffic_light_fsm;

    localparam int GREEN_S  = 25;
    localparam int YELLOW_S = 5;
    localparam int RED_S    = 30;
    localparam int PED_MIN  = 5;

    logic clk;
    logic rst_n;
    traffic_light_fsm_if bus ();

    traffic_light_fsm #(
        .GREEN_S  (GREEN_S),
        .YELLOW_S (YELLOW_S),
        .RED_S    (RED_S),
        .PED_MIN  (PED_MIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0=red, 1=green, 2=yellow; rem = seconds left shown.
    int m_phase;
    int m_rem;
    bit m_pend;
    bit m_ack;

    function automatic int phase_len(input int ph);
        case (ph)
            0: return RED_S;
            1: return GREEN_S;
            default: return YELLOW_S;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_rem   = RED_S;
        m_pend  = 1'b0;
        m_ack   = 1'b0;
    endtask

    task automatic model_update(input bit t, input bit r);
        m_ack = 1'b0;
        if (t) begin
            if (m_rem == 1) begin
                m_phase = (m_phase + 1) % 3;
                m_rem   = phase_len(m_phase);
                if (m_phase == 2) m_pend = 1'b0;
            end else if (m_phase == 1 && (m_pend || r) && m_rem > PED_MIN) begin
                m_rem  = PED_MIN;
                m_ack  = 1'b1;
                m_pend = 1'b0;
            end else begin
                m_rem = m_rem - 1;
                if (m_phase == 1 && r) m_pend = 1'b1;
            end
        end else if (m_phase == 1 && r) begin
            m_pend = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("red",      8'(bus.red),      8'(m_phase == 0));
        chk("green",    8'(bus.green),    8'(m_phase == 1));
        chk("yellow",   8'(bus.yellow),   8'(m_phase == 2));
        chk("sec_tens", 8'(bus.sec_tens), 8'(m_rem / 10));
        chk("sec_ones", 8'(bus.sec_ones), 8'(m_rem % 10));
        chk("ped_ack",  8'(bus.ped_ack),  8'(m_ack));
        chk("ped_pend", 8'(dut.ped_pend), 8'(m_pend));
    endtask

    task automatic step(input bit t, input bit r);
        @(negedge clk);
        bus.tick_1s = t;
        bus.ped_req = r;
        @(posedge clk);
        model_update(t, r);
        #1;
        check_all();
    endtask

    task automatic tick_gap(input int gap);
        step(1'b1, 1'b0);
        repeat (gap - 1) step(1'b0, 1'b0);
    endtask

    task automatic run_until(input int ph, input int rem);
        int n;
        n = 0;
        while (!(m_phase == ph && m_rem == rem) && n < 200) begin
            tick_gap(2);
            n++;
        end
        chk("run_until_bound", 8'(n < 200), 8'd1);
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.tick_1s = 1'b0;
        bus.ped_req = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tick_1s = 1'b0;
        bus.ped_req = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        repeat (1000) step(1'b0, 1'b0);

        for (int i = 0; i < 30; i++) tick_gap(10);
        chk("green_after_30", 8'(bus.green), 8'd1);
        chk("display_25", {bus.sec_tens, bus.sec_ones}, 8'h25);
        for (int i = 0; i < 30; i++) tick_gap(10);
        chk("red_after_60", 8'(bus.red), 8'd1);
        chk("display_30", {bus.sec_tens, bus.sec_ones}, 8'h30);

        run_until(1, 20);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("cut_to_05", {bus.sec_tens, bus.sec_ones}, 8'h05);
        chk("cut_ack", 8'(bus.ped_ack), 8'd1);
        step(1'b0, 1'b0);
        chk("ack_one_cycle", 8'(bus.ped_ack), 8'd0);
        for (int i = 0; i < 5; i++) tick_gap(4);
        chk("yellow_after_cut", 8'(bus.yellow), 8'd1);
        chk("yellow_05", {bus.sec_tens, bus.sec_ones}, 8'h05);

        run_until(0, 10);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        run_until(1, 3);
        for (int i = 0; i < 10 && m_phase == 1; i++) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
        end
        step(1'b0, 1'b0);
        chk("held_req_yellow", 8'(bus.yellow), 8'd1);
        chk("pend_clear_yellow", 8'(dut.ped_pend), 8'd0);

        run_until(0, 15);
        repeat (3) step(1'b1, 1'b0);
        chk("triple_tick_12", {bus.sec_tens, bus.sec_ones}, 8'h12);

        repeat (3000) step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);

        run_until(2, 3);
        step(1'b0, 1'b0);
        async_reset_check();
        chk("reset_red", 8'(bus.red), 8'd1);
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("first_tick_29", {bus.sec_tens, bus.sec_ones}, 8'h29);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Consumer side of the one-second timing path. Advances a three-phase traffic-light state machine and a two-digit BCD countdown on each single-cycle `tick_1s` enable from the divider, in the system clock domain. Also accepts a pedestrian request that shortens the green phase. Drives the lamp outputs and the seven-segment digit decoders.

## Interface
- `GREEN_S`, 25: green phase length in seconds; legal range 1..99.
- `YELLOW_S`, 5: yellow phase length in seconds; legal range 1..99.
- `RED_S`, 30: red phase length in seconds; legal range 1..99.
- `PED_MIN`, 5: remaining green seconds after a pedestrian cut; legal range 1..`GREEN_S`.
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `tick_1s`  in  1  one-cycle enable pulse, once per second.
- `ped_req`  in  1  pedestrian button, synchronous, level or pulse.
- `red`, `yellow`, `green`  out  1 each  lamp drives, one-hot.
- `sec_tens`, `sec_ones`  out  4 each  BCD remaining seconds in the current phase.
- `ped_ack`  out  1  one-cycle pulse when a pedestrian cut is applied.

## Operation
- States and transitions on the terminal tick:
  - RED → GREEN
  - GREEN → YELLOW
  - YELLOW → RED
- Lamps are a registered function of state. Exactly one lamp is high at all times, including during reset.
- Countdown:
  - On entering a phase, the count loads that phase's parameter, converted to BCD.
  - Each tick decrements the count by 1 in BCD:
    - If ones ≠ 0: ones−1.
    - If ones = 0: ones←9, tens−1.
  - The count never displays 00.
- Terminal tick: a tick arriving while the count is 01. It changes state and loads the next phase length in the same edge.
- Pedestrian latch `ped_pend`:
  - Set by `ped_req`=1 only while in GREEN.
  - Ignored in RED and YELLOW.
  - Cleared on entering YELLOW.
- Pedestrian cut, on a tick in GREEN with `ped_pend` or `ped_req` high:
  - If count > `PED_MIN`: count←`PED_MIN` (no extra decrement), `ped_ack`=1 for that cycle, `ped_pend` cleared.
  - If count ≤ `PED_MIN`: normal decrement, no ack, latch held until YELLOW.
- `tick_1s` high on consecutive cycles is treated as separate ticks. The block does not edge-detect.

## Timing
- Reset values:
  - state RED, `red`=1, `yellow`=0, `green`=0
  - count = `RED_S` in BCD
  - `ped_pend`=0, `ped_ack`=0
- Reset mid-phase returns to these values immediately and asynchronously. The first tick after deassertion decrements from `RED_S`.
- Latency: all outputs update on the same `clk` edge that samples `tick_1s`=1. Outputs are visible the following cycle, with no combinational path from inputs to outputs.
- Simultaneous events:
  - `ped_req` and tick in the same cycle in GREEN: the cut applies on that tick.
  - Terminal tick in GREEN with a request pending: go to YELLOW, no ack.
- Cycles without a tick hold all state. `ped_req` still sets the latch in GREEN.

## Structure
- Package `traffic_pkg`:
  - state enum {S_RED, S_GREEN, S_YELLOW}
  - constant function `to_bcd(int)` returning 8-bit BCD {tens, ones}
  - parameter range checks, elaboration-time assertions on the 1..99 bounds
- Sub-module `bcd_down_counter`:
  - ports: `clk`, `rst_n`, `load`, `load_val[7:0]`, `dec`, `q[7:0]`, `is_one`
  - load has priority over dec
  - instantiated once

## Test plan
- Reset release, no ticks for 1000 cycles → `red`=1, display 30, all outputs constant.
- 30 ticks spaced 10 cycles apart → display 30..01, then `green`=1 with display 25 after the 30th tick. Full cycle returns to RED after 60 ticks total.
- In GREEN at display 20, pulse `ped_req` 1 cycle between ticks → next tick: display 05, `ped_ack` high exactly 1 cycle. After 5 more ticks: YELLOW, display 05.
- `ped_req` held in GREEN at display 03 → no ack, normal countdown to YELLOW; `ped_pend`=0 in YELLOW. `ped_req` pulsed in RED → no effect in the following GREEN.
- BCD borrow: in GREEN, tick from 20 → 19, and from 10 → 09. No invalid nibble (>9) ever appears on `sec_tens` or `sec_ones`.
- Assert `rst_n` low mid-YELLOW between ticks → `red`=1 and display 30 before the next `clk` edge. `tick_1s` held high for 3 cycles → count decrements by 3.
